multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath. Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and register/memory enables.
- Drives the 3-bit alu_operation code consumed by the ALU control decoder: 000 add, 001 sub, 010 R-type funct, 100 addi, 101 andi, 111 ori.
- Waits on a memory ready handshake; a bounded timeout prevents a hang.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a memory state may wait for mem_ready before aborting; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- opcode  input  6  instruction[31:26] from the instruction register
- zero  input  1  ALU zero flag, combinational, valid in BRANCH
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_en  output  1  PC register write enable
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 0=rt, 1=rd
- mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0=PC, 1=A register
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=extended imm, 11=sign-ext imm<<2
- ext_zero  output  1  immediate extension: 1=zero-extend, 0=sign-extend
- alu_operation  output  3  ALU operation class, to the ALU control decoder
- pc_source  output  2  PC next select: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse on memory wait abort

Behaviour:
- Reset: asynchronous entry to RESET; wait counter and latched opcode cleared.
- Output defaults: every output is 0 in any state unless listed below; this includes RESET.
- RESET: all outputs 0; next state FETCH.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_operation=000, pc_source=00.
  - ir_write and pc_en are asserted only in the cycle mem_ready=1; that cycle moves to DECODE, otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_operation=000 (computes branch target); opcode latched internally.
  - Next state by opcode: 0x00 R_EXEC; 0x23/0x2B MEM_ADDR; 0x04 BRANCH; 0x08/0x0C/0x0D IMM_EXEC; 0x02 JUMP; anything else ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_operation=000. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; on mem_ready, pulse instr_done and go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_operation=010; next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_operation=001, pc_source=01.
  - pc_en=zero (Mealy on zero only); instr_done=1; next FETCH.
- IMM_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_operation = 100 (addi), 101 (andi), 111 (ori).
  - ext_zero=1 for andi/ori, 0 for addi; next IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_zero held from IMM_EXEC, instr_done=1; next FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1; next FETCH.
- ILLEGAL: illegal_op=1; next FETCH. No register or memory write occurs; the PC was already incremented in FETCH.
- Latency with mem_ready held 1: R-type 4 cycles, lw 5, sw 4, addi/andi/ori 4, beq 3, j 3.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_READ and MEM_WRITE; clears on every state change.
  - On reaching TIMEOUT_CYCLES: mem_timeout=1 and mem_read/mem_write=0 in that cycle, next FETCH.
  - FETCH timeout retries the fetch at the same PC. Load/store timeout aborts without writeback or instr_done.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins and no timeout is flagged.
- Reset mid-instruction: immediate return to RESET; the partially executed instruction is discarded.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined: opcode 0x05 goes to BRANCH with pc_en=~zero; all other BRANCH outputs are identical to beq.
- Undefined: opcode 0x05 goes to ILLEGAL.

Decomposition:
- Shared header/package mc_defs: state encodings, opcode constants, alu_operation codes, alu_src_b and pc_source encodings. The ALU control decoder uses the same alu_operation constants.
- One sub-module, mem_wait_timer: counter, clear, and timeout-flag logic parameterised by TIMEOUT_CYCLES/CNT_W.

Test Plan:
- Reset mid-R_EXEC, then release with opcode=0x00 and mem_ready=1 -> all outputs 0 during reset; then FETCH, DECODE, R_EXEC (alu_operation=010), R_WB (reg_write=1, reg_dst=1), with instr_done in cycle 4.
- lw (0x23) with mem_ready low for 3 cycles in MEM_READ -> mem_read/i_or_d held for 4 cycles, then MEM_WB with mem_to_reg=1; no early reg_write.
- beq (0x04) with zero=1, then zero=0 -> pc_en=1 with pc_source=01, then pc_en=0; alu_operation=001 both times.
- andi (0x0C) and ori (0x0D) -> IMM_EXEC alu_operation=101 then 111, ext_zero=1; addi (0x08) -> 100 with ext_zero=0.
- TIMEOUT_CYCLES=4, sw with mem_ready stuck 0 -> mem_timeout pulses after 4 wait cycles, mem_write drops, return to FETCH, no instr_done.
- opcode 0x05 -> illegal_op pulse without MC_BNE_EN; with MC_BNE_EN and zero=0, pc_en=1.

Source files
------------

// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU operation classes (also used by the ALU control decoder) and mux selects.
package mc_defs;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_R_EXEC,
        ST_R_WB,
        ST_BRANCH,
        ST_IMM_EXEC,
        ST_IMM_WB,
        ST_JUMP,
        ST_ILLEGAL
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ANDI  = 3'b101;
    localparam logic [2:0] ALU_ORI   = 3'b111;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BRANCH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Immediate-class ALU operation for the latched opcode.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_ANDI;
            OP_ORI:  return ALU_ORI;
            default: return ALU_ADDI;
        endcase
    endfunction

    // Logical immediates are zero-extended; addi sign-extends.
    function automatic logic imm_ext_zero(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory-wait cycles and flags a timeout when the
// count reaches TIMEOUT_CYCLES (0 disables). A ready memory always beats timeout.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ready_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stalled;

    assign stalled = wait_i & ~ready_i;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stalled && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = TIMEOUT_EN && stalled && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle MIPS datapath.
// Optional `MC_BNE_EN adds bne (opcode 0x05) through the BRANCH state.
module multicycle_control
    import mc_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_operation,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_e     state_q, state_d;
    logic [5:0] op_q;
    logic       in_wait;
    logic       timer_clear;
    logic       branch_taken;
    state_e     decode_target;

    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                     (state_q == ST_MEM_WRITE);

    // Counter restarts on any state change, and on a FETCH retry that stays put.
    assign timer_clear = (state_d != state_q) || mem_timeout;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .wait_i   (in_wait),
        .ready_i  (mem_ready),
        .clear_i  (timer_clear),
        .timeout_o(mem_timeout)
    );

`ifdef MC_BNE_EN
    assign branch_taken = (op_q == OP_BNE) ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        case (opcode)
            OP_RTYPE:                 decode_target = ST_R_EXEC;
            OP_LW, OP_SW:             decode_target = ST_MEM_ADDR;
            OP_BEQ:                   decode_target = ST_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:                   decode_target = ST_BRANCH;
`endif
            OP_ADDI, OP_ANDI, OP_ORI: decode_target = ST_IMM_EXEC;
            OP_J:                     decode_target = ST_JUMP;
            default:                  decode_target = ST_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        ext_zero      = 1'b0;
        alu_operation = ALU_ADD;
        pc_source     = PC_SRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = ~mem_timeout;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_BRANCH;
                state_d   = decode_target;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = ~mem_timeout;
                if (mem_ready)        state_d = ST_MEM_WB;
                else if (mem_timeout) state_d = ST_FETCH;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = ~mem_timeout;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else if (mem_timeout) begin
                    state_d = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                alu_src_a     = 1'b1;
                alu_operation = ALU_FUNCT;
                state_d       = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_operation = ALU_SUB;
                pc_source     = PC_SRC_ALUOUT;
                pc_en         = branch_taken;
                instr_done    = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_IMM_EXEC: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_IMM;
                alu_operation = imm_alu_op(op_q);
                ext_zero      = imm_ext_zero(op_q);
                state_d       = ST_IMM_WB;
            end
            ST_IMM_WB: begin
                reg_write  = 1'b1;
                ext_zero   = imm_ext_zero(op_q);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_source  = PC_SRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) op_q <= opcode;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT_CYCLES=4): expected output
// vectors are queued with each stimulus step and popped when the DUT settles.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_operation;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } outv_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    outv_t      obs;

    outv_t      exp_q[$];
    string      tag_q[$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_en        (obs.pc_en),
        .i_or_d       (obs.i_or_d),
        .mem_read     (obs.mem_read),
        .mem_write    (obs.mem_write),
        .ir_write     (obs.ir_write),
        .reg_dst      (obs.reg_dst),
        .mem_to_reg   (obs.mem_to_reg),
        .reg_write    (obs.reg_write),
        .alu_src_a    (obs.alu_src_a),
        .alu_src_b    (obs.alu_src_b),
        .ext_zero     (obs.ext_zero),
        .alu_operation(obs.alu_operation),
        .pc_source    (obs.pc_source),
        .instr_done   (obs.instr_done),
        .illegal_op   (obs.illegal_op),
        .mem_timeout  (obs.mem_timeout)
    );

    // Expected output vectors, one per control state.
    function automatic outv_t o_none();
        outv_t o = '0;
        return o;
    endfunction
    function automatic outv_t o_fetch(input logic rdy);
        outv_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy;
        return o;
    endfunction
    function automatic outv_t o_fetch_to();
        outv_t o = '0;
        o.alu_src_b = 2'b01; o.mem_timeout = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_decode();
        outv_t o = '0;
        o.alu_src_b = 2'b11;
        return o;
    endfunction
    function automatic outv_t o_mem_addr();
        outv_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outv_t o_mem_read();
        outv_t o = '0;
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_mem_wb();
        outv_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_mem_write(input logic rdy);
        outv_t o = '0;
        o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy;
        return o;
    endfunction
    function automatic outv_t o_mem_write_to();
        outv_t o = '0;
        o.i_or_d = 1'b1; o.mem_timeout = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_r_exec();
        outv_t o = '0;
        o.alu_src_a = 1'b1; o.alu_operation = 3'b010;
        return o;
    endfunction
    function automatic outv_t o_r_wb();
        outv_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_branch(input logic taken);
        outv_t o = '0;
        o.alu_src_a = 1'b1; o.alu_operation = 3'b001; o.pc_source = 2'b01;
        o.pc_en = taken; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_imm_exec(input logic [2:0] aop, input logic ez);
        outv_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_operation = aop; o.ext_zero = ez;
        return o;
    endfunction
    function automatic outv_t o_imm_wb(input logic ez);
        outv_t o = '0;
        o.reg_write = 1'b1; o.ext_zero = ez; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_jump();
        outv_t o = '0;
        o.pc_source = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_illegal();
        outv_t o = '0;
        o.illegal_op = 1'b1;
        return o;
    endfunction

    // Push the expectation, let the DUT settle, then pop and compare.
    task automatic check_now(input outv_t exp, input string tag);
        outv_t e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic step(input logic rdy, input logic z, input logic [5:0] op,
                        input outv_t exp, input string tag);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        check_now(exp, tag);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        step(1, 0, 6'h00, o_none(), "reset_hold0");
        step(1, 0, 6'h00, o_none(), "reset_hold1");

        // R-type interrupted by reset in R_EXEC
        reset = 1'b0;
        step(1, 0, 6'h00, o_none(),     "reset_state");
        step(1, 0, 6'h00, o_fetch(1'b1), "r0_fetch");
        step(1, 0, 6'h00, o_decode(),    "r0_decode");
        mem_ready = 1'b1;
        check_now(o_r_exec(), "r0_exec");
        reset = 1'b1;
        check_now(o_none(), "reset_mid_exec");
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 6'h00, o_none(),      "reset_release");
        step(1, 0, 6'h00, o_fetch(1'b1), "r_fetch");
        step(1, 0, 6'h00, o_decode(),    "r_decode");
        step(1, 0, 6'h00, o_r_exec(),    "r_exec");
        step(1, 0, 6'h00, o_r_wb(),      "r_wb");

        // lw with one fetch stall and three MEM_READ stalls
        step(0, 0, 6'h23, o_fetch(1'b0), "lw_fetch_wait");
        step(1, 0, 6'h23, o_fetch(1'b1), "lw_fetch");
        step(1, 0, 6'h23, o_decode(),    "lw_decode");
        step(1, 0, 6'h23, o_mem_addr(),  "lw_mem_addr");
        for (int i = 0; i < 3; i++) step(0, 0, 6'h23, o_mem_read(), "lw_read_wait");
        step(1, 0, 6'h23, o_mem_read(), "lw_read_done");
        step(1, 0, 6'h23, o_mem_wb(),   "lw_wb");

        // beq taken, then not taken
        step(1, 0, 6'h04, o_fetch(1'b1),  "beq_fetch");
        step(1, 0, 6'h04, o_decode(),     "beq_decode");
        step(1, 1, 6'h04, o_branch(1'b1), "beq_taken");
        step(1, 1, 6'h04, o_fetch(1'b1),  "beq2_fetch");
        step(1, 1, 6'h04, o_decode(),     "beq2_decode");
        step(1, 0, 6'h04, o_branch(1'b0), "beq_not_taken");

        // immediates
        step(1, 0, 6'h0C, o_fetch(1'b1),              "andi_fetch");
        step(1, 0, 6'h0C, o_decode(),                 "andi_decode");
        step(1, 0, 6'h0C, o_imm_exec(3'b101, 1'b1),   "andi_exec");
        step(1, 0, 6'h0C, o_imm_wb(1'b1),             "andi_wb");
        step(1, 0, 6'h0D, o_fetch(1'b1),              "ori_fetch");
        step(1, 0, 6'h0D, o_decode(),                 "ori_decode");
        step(1, 0, 6'h0D, o_imm_exec(3'b111, 1'b1),   "ori_exec");
        step(1, 0, 6'h0D, o_imm_wb(1'b1),             "ori_wb");
        step(1, 0, 6'h08, o_fetch(1'b1),              "addi_fetch");
        step(1, 0, 6'h08, o_decode(),                 "addi_decode");
        step(1, 0, 6'h08, o_imm_exec(3'b100, 1'b0),   "addi_exec");
        step(1, 0, 6'h08, o_imm_wb(1'b0),             "addi_wb");

        // sw with memory stuck: four wait cycles then timeout abort
        step(1, 0, 6'h2B, o_fetch(1'b1), "sw_to_fetch");
        step(1, 0, 6'h2B, o_decode(),    "sw_to_decode");
        step(1, 0, 6'h2B, o_mem_addr(),  "sw_to_mem_addr");
        for (int i = 0; i < 4; i++) step(0, 0, 6'h2B, o_mem_write(1'b0), "sw_to_wait");
        step(0, 0, 6'h2B, o_mem_write_to(), "sw_timeout");

        // sw whose ready arrives exactly at the timeout count
        step(1, 0, 6'h2B, o_fetch(1'b1), "sw_fetch");
        step(1, 0, 6'h2B, o_decode(),    "sw_decode");
        step(1, 0, 6'h2B, o_mem_addr(),  "sw_mem_addr");
        for (int i = 0; i < 4; i++) step(0, 0, 6'h2B, o_mem_write(1'b0), "sw_wait");
        step(1, 0, 6'h2B, o_mem_write(1'b1), "sw_ready_at_limit");

        // fetch timeout retries the fetch, then j
        for (int i = 0; i < 4; i++) step(0, 0, 6'h02, o_fetch(1'b0), "fetch_wait");
        step(0, 0, 6'h02, o_fetch_to(),   "fetch_timeout");
        step(0, 0, 6'h02, o_fetch(1'b0),  "fetch_retry");
        step(1, 0, 6'h02, o_fetch(1'b1),  "j_fetch");
        step(1, 0, 6'h02, o_decode(),     "j_decode");
        step(1, 0, 6'h02, o_jump(),       "j_jump");

        // opcode 0x05 and a plainly unsupported opcode
        step(1, 0, 6'h05, o_fetch(1'b1), "op05_fetch");
        step(1, 0, 6'h05, o_decode(),    "op05_decode");
`ifdef MC_BNE_EN
        step(1, 0, 6'h05, o_branch(1'b1), "bne_taken");
`else
        step(1, 0, 6'h05, o_illegal(),    "op05_illegal");
`endif
        step(1, 0, 6'h3F, o_fetch(1'b1), "ill_fetch");
        step(1, 0, 6'h3F, o_decode(),    "ill_decode");
        step(1, 0, 6'h3F, o_illegal(),   "ill_illegal");
        step(0, 0, 6'h00, o_fetch(1'b0), "final_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
